// File: rtl/multicycle_controller_pkg.sv
// Shared definitions for the multicycle controller.
// Holds the FSM state enumeration, instruction class and control-type
// encodings, datapath mux select encodings, the registered output bundle
// and the conditional-branch evaluation helper.
package multicycle_controller_pkg;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB
  } state_t;

  typedef enum logic [2:0] {
    CLS_ALU_R,
    CLS_ALU_I,
    CLS_SHIFT,
    CLS_MEM,
    CLS_CTRL
  } instr_class_t;

  typedef enum logic [2:0] {
    CT_JMP = 3'd0,
    CT_JSB = 3'd1,
    CT_RET = 3'd2,
    CT_NOP = 3'd3,
    CT_BZ  = 3'd4,
    CT_BNZ = 3'd5,
    CT_BC  = 3'd6,
    CT_BNC = 3'd7
  } ctrl_type_t;

  // PC input mux
  localparam logic [1:0] PC_SEL_INC  = 2'd0;  // PC+1
  localparam logic [1:0] PC_SEL_DISP = 2'd1;  // PC+1+disp
  localparam logic [1:0] PC_SEL_ABS  = 2'd2;  // instr[11:0]

  // Register-file write data mux
  localparam logic [1:0] WD_SEL_ALU   = 2'd0;
  localparam logic [1:0] WD_SEL_SHIFT = 2'd1;
  localparam logic [1:0] WD_SEL_MEM   = 2'd2;

  // Register-file read port 2 address mux
  localparam logic RR2_SEL_RD = 1'b0;  // instr[13:11]
  localparam logic RR2_SEL_RT = 1'b1;  // instr[7:5]

  // ALU B input mux
  localparam logic ALUB_SEL_IMM = 1'b0;
  localparam logic ALUB_SEL_REG = 1'b1;

  typedef struct packed {
    logic       pc_en;
    logic       c_en;
    logic       z_en;
    logic       reg_write;
    logic       mem_write;
    logic       mem_read;
    logic       push;
    logic       pop;
    logic       ret;
    logic       rr2_sel;
    logic       alub_sel;
    logic [2:0] alu_op;
    logic [1:0] shro_op;
    logic [1:0] wd_sel;
    logic [1:0] pc_sel;
    logic       instr_done;
  } ctrl_out_t;

  function automatic logic branch_taken(input ctrl_type_t ct, input logic c, input logic z);
    logic taken;
    taken = 1'b0;
    case (ct)
      CT_BZ:   taken = z;
      CT_BNZ:  taken = ~z;
      CT_BC:   taken = c;
      CT_BNC:  taken = ~c;
      default: taken = 1'b0;
    endcase
    return taken;
  endfunction

endpackage

// File: rtl/multicycle_controller_if.sv
// Controller <-> datapath bundle.
// master: the controller (reads instruction and flags, drives strobes/selects).
// slave:  the datapath (drives instruction and flags, consumes strobes/selects).
interface multicycle_controller_if;
  logic [18:0] instruction;
  logic        COutput;
  logic        ZOutput;
  logic        pcEn;
  logic        CEn;
  logic        ZEn;
  logic        regWrite;
  logic        DMMemWrite;
  logic        DMMemRead;
  logic        push;
  logic        pop;
  logic        RET;
  logic        regFileReadRegister2Select;
  logic        ALUBInputSelect;
  logic [2:0]  ALUOperation;
  logic [1:0]  SHROOperation;
  logic [1:0]  regFileWriteDataSelect;
  logic [1:0]  pc3inputMuxSelectAddress;
  logic        instrDone;

  modport master (
    input  instruction, COutput, ZOutput,
    output pcEn, CEn, ZEn, regWrite, DMMemWrite, DMMemRead, push, pop, RET,
           regFileReadRegister2Select, ALUBInputSelect, ALUOperation,
           SHROOperation, regFileWriteDataSelect, pc3inputMuxSelectAddress,
           instrDone
  );

  modport slave (
    output instruction, COutput, ZOutput,
    input  pcEn, CEn, ZEn, regWrite, DMMemWrite, DMMemRead, push, pop, RET,
           regFileReadRegister2Select, ALUBInputSelect, ALUOperation,
           SHROOperation, regFileWriteDataSelect, pc3inputMuxSelectAddress,
           instrDone
  );
endinterface

// File: rtl/instr_decode.sv
// Combinational opcode decode.
// Ports:
//   opcode      in  7  instruction[18:12]
//   instr_class out    ALU R-type / ALU immediate / shift / memory / control
//   is_store    out 1  memory class: 0 = LM, 1 = SM
//   ctrl_type   out    control class sub-type
//   alu_op      out 3  instruction[16:14]
//   shro_op     out 2  instruction[15:14]
module instr_decode
  import multicycle_controller_pkg::*;
(
  input  logic [6:0]   opcode,
  output instr_class_t instr_class,
  output logic         is_store,
  output ctrl_type_t   ctrl_type,
  output logic [2:0]   alu_op,
  output logic [1:0]   shro_op
);

  always_comb begin
    instr_class = CLS_CTRL;
    if (opcode[6:5] == 2'b00)
      instr_class = CLS_ALU_R;
    else if (opcode[6:5] == 2'b01)
      instr_class = CLS_ALU_I;
    else if (opcode[6:4] == 3'b110)
      instr_class = CLS_SHIFT;
    else if (opcode[6:3] == 4'b1110)
      instr_class = CLS_MEM;
  end

  assign is_store  = opcode[2];
  assign ctrl_type = ctrl_type_t'(opcode[2:0]);
  assign alu_op    = opcode[4:2];
  assign shro_op   = opcode[3:2];

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle FSM controller: FETCH -> DECODE -> EXEC [-> MEM [-> WB]].
// Ports:
//   clk  in  sole clock, rising edge
//   rst  in  asynchronous active-high reset; returns to FETCH with all outputs 0
//   bus  master modport of multicycle_controller_if (instruction, flags,
//        datapath strobes, mux selects, instrDone)
// Every output is a register loaded on the edge entering the state it belongs
// to, so the branch flags are captured on the edge that enters EXEC.
module multicycle_controller
  import multicycle_controller_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  multicycle_controller_if.master bus
);

  state_t       state;
  ctrl_out_t    out_q;
  instr_class_t instr_class;
  logic         is_store;
  ctrl_type_t   ctrl_type;
  logic [2:0]   alu_op;
  logic [1:0]   shro_op;

  // Operand fields are consumed by the datapath, not the controller.
  logic unused_operand_bits;
  assign unused_operand_bits = ^bus.instruction[11:0];

  instr_decode u_decode (
    .opcode      (bus.instruction[18:12]),
    .instr_class (instr_class),
    .is_store    (is_store),
    .ctrl_type   (ctrl_type),
    .alu_op      (alu_op),
    .shro_op     (shro_op)
  );

  function automatic ctrl_out_t exec_outputs(
    input instr_class_t cls,
    input ctrl_type_t   ct,
    input logic [2:0]   aop,
    input logic [1:0]   sop,
    input logic         c,
    input logic         z
  );
    ctrl_out_t o;
    o = '0;
    case (cls)
      CLS_ALU_R, CLS_ALU_I: begin
        o.alu_op    = aop;
        o.alub_sel  = (cls == CLS_ALU_R) ? ALUB_SEL_REG : ALUB_SEL_IMM;
        o.rr2_sel   = RR2_SEL_RT;
        o.reg_write = 1'b1;
        o.c_en      = 1'b1;
        o.z_en      = 1'b1;
        o.wd_sel    = WD_SEL_ALU;
        o.pc_en     = 1'b1;
      end
      CLS_SHIFT: begin
        o.shro_op   = sop;
        o.wd_sel    = WD_SEL_SHIFT;
        o.reg_write = 1'b1;
        o.pc_en     = 1'b1;
      end
      CLS_CTRL: begin
        o.pc_en = 1'b1;
        case (ct)
          CT_JMP: o.pc_sel = PC_SEL_ABS;
          CT_JSB: begin
            o.pc_sel = PC_SEL_ABS;
            o.push   = 1'b1;
          end
          CT_RET: begin
            o.ret = 1'b1;
            o.pop = 1'b1;
          end
          CT_NOP: o.pc_sel = PC_SEL_INC;
          default: o.pc_sel = branch_taken(ct, c, z) ? PC_SEL_DISP : PC_SEL_INC;
        endcase
      end
      default: ;  // memory instructions idle in EXEC
    endcase
    o.instr_done = o.pc_en;
    return o;
  endfunction

  function automatic ctrl_out_t mem_outputs(input logic store);
    ctrl_out_t o;
    o = '0;
    if (store) begin
      o.rr2_sel    = RR2_SEL_RD;
      o.mem_write  = 1'b1;
      o.pc_en      = 1'b1;
      o.instr_done = 1'b1;
    end else begin
      o.mem_read = 1'b1;
    end
    return o;
  endfunction

  function automatic ctrl_out_t wb_outputs();
    ctrl_out_t o;
    o = '0;
    o.mem_read   = 1'b1;
    o.wd_sel     = WD_SEL_MEM;
    o.reg_write  = 1'b1;
    o.pc_en      = 1'b1;
    o.instr_done = 1'b1;
    return o;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_FETCH;
      out_q <= '0;
    end else begin
      out_q <= '0;
      unique case (state)
        S_FETCH: state <= S_DECODE;
        S_DECODE: begin
          state <= S_EXEC;
          out_q <= exec_outputs(instr_class, ctrl_type, alu_op, shro_op,
                                bus.COutput, bus.ZOutput);
        end
        S_EXEC: begin
          if (instr_class == CLS_MEM) begin
            state <= S_MEM;
            out_q <= mem_outputs(is_store);
          end else begin
            state <= S_FETCH;
          end
        end
        S_MEM: begin
          if (!is_store) begin
            state <= S_WB;
            out_q <= wb_outputs();
          end else begin
            state <= S_FETCH;
          end
        end
        S_WB:    state <= S_FETCH;
        default: state <= S_FETCH;
      endcase
    end
  end

  assign bus.pcEn                       = out_q.pc_en;
  assign bus.CEn                        = out_q.c_en;
  assign bus.ZEn                        = out_q.z_en;
  assign bus.regWrite                   = out_q.reg_write;
  assign bus.DMMemWrite                 = out_q.mem_write;
  assign bus.DMMemRead                  = out_q.mem_read;
  assign bus.push                       = out_q.push;
  assign bus.pop                        = out_q.pop;
  assign bus.RET                        = out_q.ret;
  assign bus.regFileReadRegister2Select = out_q.rr2_sel;
  assign bus.ALUBInputSelect            = out_q.alub_sel;
  assign bus.ALUOperation               = out_q.alu_op;
  assign bus.SHROOperation              = out_q.shro_op;
  assign bus.regFileWriteDataSelect     = out_q.wd_sel;
  assign bus.pc3inputMuxSelectAddress   = out_q.pc_sel;
  assign bus.instrDone                  = out_q.instr_done;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller. Instructions are applied in the
// FETCH cycle and held until the cycle after pcEn; outputs are sampled 1 time
// unit after each falling edge.
module tb_multicycle_controller;

  logic clk;
  logic rst;
  int   passed;
  int   total;

  multicycle_controller_if bus_if ();

  multicycle_controller dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got running expected finished");
    $fatal(1, "watchdog");
  end

  // {pcEn,CEn,ZEn,regWrite,DMMemWrite,DMMemRead,push,pop,RET,rr2,aluB,ALUOp,SHROp,wdSel,pcSel,instrDone}
  function automatic logic [20:0] outs();
    return {bus_if.pcEn, bus_if.CEn, bus_if.ZEn, bus_if.regWrite, bus_if.DMMemWrite,
            bus_if.DMMemRead, bus_if.push, bus_if.pop, bus_if.RET,
            bus_if.regFileReadRegister2Select, bus_if.ALUBInputSelect,
            bus_if.ALUOperation, bus_if.SHROOperation, bus_if.regFileWriteDataSelect,
            bus_if.pc3inputMuxSelectAddress, bus_if.instrDone};
  endfunction

  function automatic logic [20:0] ev(
    input logic pc, input logic c, input logic z, input logic rw, input logic mw,
    input logic mr, input logic pu, input logic po, input logic rt,
    input logic r2, input logic ab, input logic [2:0] ao, input logic [1:0] so,
    input logic [1:0] ws, input logic [1:0] ps, input logic dn);
    return {pc, c, z, rw, mw, mr, pu, po, rt, r2, ab, ao, so, ws, ps, dn};
  endfunction

  function automatic logic [18:0] i_r(input logic [2:0] op, input logic [2:0] rd,
                                      input logic [2:0] rs, input logic [2:0] rt);
    return {2'b00, op, rd, rs, rt, 5'b00000};
  endfunction

  function automatic logic [18:0] i_i(input logic [2:0] op, input logic [2:0] rd,
                                      input logic [7:0] imm);
    return {2'b01, op, rd, 3'd1, imm};
  endfunction

  function automatic logic [18:0] i_s(input logic [1:0] op, input logic [2:0] rd);
    return {3'b110, op, rd, 3'd2, 8'h00};
  endfunction

  function automatic logic [18:0] i_m(input logic st, input logic [2:0] rd,
                                      input logic [7:0] disp);
    return {4'b1110, st, rd, 3'd1, disp};
  endfunction

  function automatic logic [18:0] i_c(input logic [2:0] ct, input logic [11:0] addr);
    return {4'b1111, ct, addr};
  endfunction

  // Advance to the next FETCH cycle and present an instruction.
  task automatic start_instr(input logic [18:0] ins, input logic c, input logic z);
    @(negedge clk);
    bus_if.instruction = ins;
    bus_if.COutput     = c;
    bus_if.ZOutput     = z;
    #1;
  endtask

  task automatic next_cycle();
    @(negedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus_if.instruction = i_r(3'b111, 3'd1, 3'd2, 3'd3);
    @(negedge clk);
    #1;
    total++;
    if (outs() !== 21'd0) $display("FAIL reset_outputs: got %h expected %h", outs(), 21'd0);
    else passed++;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_rtype();
    logic [20:0] exp_v [3];
    exp_v[0] = '0;
    exp_v[1] = '0;
    exp_v[2] = ev(1,1,1,1,0,0,0,0,0,1,1,3'b010,2'd0,2'd0,2'd0,1);
    start_instr(i_r(3'b010, 3'd3, 3'd1, 3'd2), 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      if (i > 0) next_cycle();
      total++;
      if (outs() !== exp_v[i])
        $display("FAIL rtype cycle %0d: got %h expected %h", i + 1, outs(), exp_v[i]);
      else passed++;
    end
  endtask

  task automatic test_imm_shift();
    logic [18:0] ins   [3];
    logic [20:0] exp_v [3];
    logic [20:0] pre;
    ins[0]   = i_i(3'b101, 3'd2, 8'h7F);
    exp_v[0] = ev(1,1,1,1,0,0,0,0,0,1,0,3'b101,2'd0,2'd0,2'd0,1);
    ins[1]   = i_s(2'b11, 3'd4);
    exp_v[1] = ev(1,0,0,1,0,0,0,0,0,0,0,3'b000,2'b11,2'd1,2'd0,1);
    ins[2]   = i_s(2'b01, 3'd6);
    exp_v[2] = ev(1,0,0,1,0,0,0,0,0,0,0,3'b000,2'b01,2'd1,2'd0,1);
    for (int k = 0; k < 3; k++) begin
      start_instr(ins[k], 1'b1, 1'b1);
      pre = outs();
      next_cycle();
      pre = pre | outs();
      next_cycle();
      total++;
      if (pre !== 21'd0) $display("FAIL imm_shift_fetch_decode %0d: got %h expected %h", k, pre, 21'd0);
      else passed++;
      total++;
      if (outs() !== exp_v[k]) $display("FAIL imm_shift_exec %0d: got %h expected %h", k, outs(), exp_v[k]);
      else passed++;
    end
  endtask

  task automatic test_load();
    logic [20:0] exp_v [5];
    exp_v[0] = '0;
    exp_v[1] = '0;
    exp_v[2] = '0;
    exp_v[3] = ev(0,0,0,0,0,1,0,0,0,0,0,3'b000,2'd0,2'd0,2'd0,0);
    exp_v[4] = ev(1,0,0,1,0,1,0,0,0,0,0,3'b000,2'd0,2'd2,2'd0,1);
    start_instr(i_m(1'b0, 3'd5, 8'h04), 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      if (i > 0) next_cycle();
      total++;
      if (outs() !== exp_v[i])
        $display("FAIL load cycle %0d: got %h expected %h", i + 1, outs(), exp_v[i]);
      else passed++;
    end
  endtask

  task automatic test_store();
    logic [20:0] exp_v [4];
    exp_v[0] = '0;
    exp_v[1] = '0;
    exp_v[2] = '0;
    exp_v[3] = ev(1,0,0,0,1,0,0,0,0,0,0,3'b000,2'd0,2'd0,2'd0,1);
    start_instr(i_m(1'b1, 3'd2, 8'h10), 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      if (i > 0) next_cycle();
      total++;
      if (outs() !== exp_v[i])
        $display("FAIL store cycle %0d: got %h expected %h", i + 1, outs(), exp_v[i]);
      else passed++;
    end
  endtask

  task automatic test_branch();
    logic [2:0] ct  [8];
    logic       cf  [8];
    logic       zf  [8];
    logic [1:0] sel [8];
    logic [20:0] e;
    ct  = '{3'd4, 3'd4, 3'd5, 3'd5, 3'd6, 3'd6, 3'd7, 3'd7};
    cf  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    zf  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    sel = '{2'd1, 2'd0, 2'd1, 2'd0, 2'd1, 2'd0, 2'd1, 2'd0};
    for (int k = 0; k < 8; k++) begin
      e = ev(1,0,0,0,0,0,0,0,0,0,0,3'b000,2'd0,2'd0,sel[k],1);
      start_instr(i_c(ct[k], 12'h0FE), cf[k], zf[k]);
      next_cycle();
      next_cycle();
      total++;
      if (outs() !== e) $display("FAIL branch %0d type %0d C=%0d Z=%0d: got %h expected %h",
                                 k, ct[k], cf[k], zf[k], outs(), e);
      else passed++;
    end
  endtask

  task automatic test_jump_call_return();
    logic [18:0] ins   [4];
    logic [20:0] exp_v [4];
    logic        both;
    ins[0]   = i_c(3'd1, 12'h123);
    exp_v[0] = ev(1,0,0,0,0,0,1,0,0,0,0,3'b000,2'd0,2'd0,2'd2,1);
    ins[1]   = i_c(3'd2, 12'h000);
    exp_v[1] = ev(1,0,0,0,0,0,0,1,1,0,0,3'b000,2'd0,2'd0,2'd0,1);
    ins[2]   = i_c(3'd0, 12'h3A5);
    exp_v[2] = ev(1,0,0,0,0,0,0,0,0,0,0,3'b000,2'd0,2'd0,2'd2,1);
    ins[3]   = i_c(3'd3, 12'h000);
    exp_v[3] = ev(1,0,0,0,0,0,0,0,0,0,0,3'b000,2'd0,2'd0,2'd0,1);
    both = 1'b0;
    for (int k = 0; k < 4; k++) begin
      start_instr(ins[k], 1'b1, 1'b1);
      both = both | (bus_if.push & bus_if.pop);
      next_cycle();
      both = both | (bus_if.push & bus_if.pop);
      next_cycle();
      both = both | (bus_if.push & bus_if.pop);
      total++;
      if (outs() !== exp_v[k]) $display("FAIL ctrl_exec %0d: got %h expected %h", k, outs(), exp_v[k]);
      else passed++;
    end
    total++;
    if (both !== 1'b0) $display("FAIL push_pop_together: got %0d expected 0", both);
    else passed++;
  endtask

  task automatic test_reset_mid();
    logic [20:0] e;
    start_instr(i_m(1'b0, 3'd5, 8'h04), 1'b0, 1'b0);
    next_cycle();
    next_cycle();
    next_cycle();
    total++;
    if (bus_if.DMMemRead !== 1'b1) $display("FAIL reset_mid_in_mem: got DMMemRead=%0d expected 1", bus_if.DMMemRead);
    else passed++;
    rst = 1'b1;
    #1;
    total++;
    if (outs() !== 21'd0) $display("FAIL reset_mid_immediate: got %h expected %h", outs(), 21'd0);
    else passed++;
    @(posedge clk);
    #1;
    total++;
    if (bus_if.regWrite !== 1'b0) $display("FAIL reset_mid_no_write: got regWrite=%0d expected 0", bus_if.regWrite);
    else passed++;
    rst = 1'b0;
    e = ev(1,0,0,0,0,0,0,0,0,0,0,3'b000,2'd0,2'd0,2'd0,1);
    start_instr(i_c(3'd3, 12'h000), 1'b0, 1'b0);
    total++;
    if (outs() !== 21'd0) $display("FAIL reset_nop_fetch: got %h expected %h", outs(), 21'd0);
    else passed++;
    next_cycle();
    next_cycle();
    total++;
    if (outs() !== e) $display("FAIL reset_nop_exec: got %h expected %h", outs(), e);
    else passed++;
  endtask

  task automatic test_random_stream();
    int n_instr;
    int pc_cnt;
    int done_cnt;
    int viol;
    int exp_lat;
    int got_lat;
    int cyc;
    logic [18:0] ins;
    n_instr  = 40;
    pc_cnt   = 0;
    done_cnt = 0;
    viol     = 0;
    for (int k = 0; k < n_instr; k++) begin
      ins = 19'($urandom);
      if (ins[18:15] == 4'b1110) exp_lat = ins[14] ? 4 : 5;
      else exp_lat = 3;
      start_instr(ins, 1'($urandom), 1'($urandom));
      got_lat = 0;
      cyc = 1;
      while (cyc <= 6 && got_lat == 0) begin
        if (cyc > 1) next_cycle();
        if (bus_if.regWrite && bus_if.DMMemWrite) viol++;
        if (cyc <= 2 && (bus_if.regWrite || bus_if.DMMemWrite)) viol++;
        if (bus_if.pcEn) pc_cnt++;
        if (bus_if.instrDone) done_cnt++;
        if (bus_if.pcEn) got_lat = cyc;
        cyc++;
      end
      total++;
      if (got_lat != exp_lat)
        $display("FAIL stream_latency instr %0d (%h): got %0d cycles expected %0d", k, ins, got_lat, exp_lat);
      else passed++;
    end
    total++;
    if (pc_cnt != n_instr) $display("FAIL stream_pcEn_count: got %0d expected %0d", pc_cnt, n_instr);
    else passed++;
    total++;
    if (done_cnt != n_instr) $display("FAIL stream_instrDone_count: got %0d expected %0d", done_cnt, n_instr);
    else passed++;
    total++;
    if (viol != 0) $display("FAIL stream_write_rules: got %0d violations expected 0", viol);
    else passed++;
  endtask

  initial begin
    passed = 0;
    total  = 0;
    rst    = 1'b1;
    bus_if.instruction = '0;
    bus_if.COutput     = 1'b0;
    bus_if.ZOutput     = 1'b0;
    test_reset();
    test_rtype();
    test_imm_shift();
    test_load();
    test_store();
    test_branch();
    test_jump_call_return();
    test_reset_mid();
    test_random_stream();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
